// File: rtl/stage_wb.sv
// Write-back stage: MEM/WB pipeline register, load extraction, register-file write
// selection, architectural HI/LO registers with forwarding, and a retired-instruction counter.
module stage_wb #(
    parameter int unsigned        DW       = 32,
    parameter int unsigned        AW       = 5,
    parameter logic [DW-1:0]      HILO_RST = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_i_valid,
    input  logic                  wb_i_stall,
    input  logic                  wb_i_flush,
    input  logic                  wb_i_dm2rf,
    input  logic                  wb_i_hilowe,
    input  logic                  wb_i_rfwe,
    input  logic                  wb_i_ldsign,
    input  logic [3:0]            wb_i_bytesel,
    input  logic [AW-1:0]         wb_i_rfwa,
    input  logic [2*DW-1:0]       wb_i_mulres,
    input  logic [DW-1:0]         wb_i_alures,
    input  logic [DW-1:0]         wb_i_dmdout,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_wa,
    output logic [DW-1:0]         rf_wd,
    output logic [DW-1:0]         hi_o,
    output logic [DW-1:0]         lo_o,
    output logic [31:0]           instret
);

    logic              valid_d;
    logic              valid_q;
    logic              dm2rf_q;
    logic              hilowe_q;
    logic              rfwe_q;
    logic              ldsign_q;
    logic [3:0]        bytesel_q;
    logic [AW-1:0]     rfwa_q;
    logic [2*DW-1:0]   mulres_q;
    logic [DW-1:0]     alures_q;
    logic [DW-1:0]     dmdout_q;
    logic [DW-1:0]     hi_q;
    logic [DW-1:0]     lo_q;
    logic [31:0]       instret_q;
    logic [DW-1:0]     load_data;
    logic              hilo_fwd;

    // Stall and flush both turn the slot into a bubble; a stalled instruction enters once on release.
    assign valid_d = wb_i_valid & ~wb_i_stall & ~wb_i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            dm2rf_q   <= 1'b0;
            hilowe_q  <= 1'b0;
            rfwe_q    <= 1'b0;
            ldsign_q  <= 1'b0;
            bytesel_q <= '0;
            rfwa_q    <= '0;
            mulres_q  <= '0;
            alures_q  <= '0;
            dmdout_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (valid_d) begin
                dm2rf_q   <= wb_i_dm2rf;
                hilowe_q  <= wb_i_hilowe;
                rfwe_q    <= wb_i_rfwe;
                ldsign_q  <= wb_i_ldsign;
                bytesel_q <= wb_i_bytesel;
                rfwa_q    <= wb_i_rfwa;
                mulres_q  <= wb_i_mulres;
                alures_q  <= wb_i_alures;
                dmdout_q  <= wb_i_dmdout;
            end
        end
    end

    assign hilo_fwd = valid_q & hilowe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= HILO_RST;
            lo_q <= HILO_RST;
        end else if (hilo_fwd) begin
            hi_q <= mulres_q[2*DW-1:DW];
            lo_q <= mulres_q[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (valid_q) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    // Unrecognised width codes fall back to a full-word load.
    always_comb begin
        load_data = dmdout_q;
        case (bytesel_q)
            4'b0011: load_data = {{(DW-16){ldsign_q & dmdout_q[15]}}, dmdout_q[15:0]};
            4'b0001: load_data = {{(DW-8){ldsign_q & dmdout_q[7]}}, dmdout_q[7:0]};
            default: load_data = dmdout_q;
        endcase
    end

    assign rf_we   = valid_q & rfwe_q & (rfwa_q != '0);
    assign rf_wa   = rfwa_q;
    assign rf_wd   = dm2rf_q ? load_data : alures_q;
    assign hi_o    = hilo_fwd ? mulres_q[2*DW-1:DW] : hi_q;
    assign lo_o    = hilo_fwd ? mulres_q[DW-1:0] : lo_q;
    assign instret = instret_q;

endmodule

// File: doc/stage_wb.md
# stage_wb

Write-back stage of the five-stage MIPS pipeline. It is fed by the memory stage outputs and contains the MEM/WB pipeline register. It extracts load data, selects the register-file write value, and owns the architectural HI/LO registers with same-cycle forwarding. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `DW`, 32: data/register width.
- `AW`, 5: register-file address width.
- `HILO_RST`, 0: reset value of HI and LO.

Ports (clock and reset asynchronous, active-low; all other ports synchronous to `clk`):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wb_i_valid`  in  1  MEM holds a real instruction (0 = bubble).
- `wb_i_stall`  in  1  MEM stalled this cycle; WB receives a bubble.
- `wb_i_flush`  in  1  kill the instruction leaving MEM; WB receives a bubble.
- `wb_i_dm2rf`  in  1  write-back source is load data (1) or ALU result (0).
- `wb_i_hilowe`  in  1  instruction writes HI/LO from `wb_i_mulres`.
- `wb_i_rfwe`  in  1  instruction writes the register file.
- `wb_i_ldsign`  in  1  sign-extend sub-word loads (0 = zero-extend).
- `wb_i_bytesel`  in  4  load width: 1111 word, 0011 half, 0001 byte.
- `wb_i_rfwa`  in  AW  destination register.
- `wb_i_mulres`  in  2*DW  {HI,LO} product/quotient.
- `wb_i_alures`  in  DW  ALU result.
- `wb_i_dmdout`  in  DW  data-memory read word, valid in the MEM cycle.
- `rf_we`  out  1  register-file write enable.
- `rf_wa`  out  AW  register-file write address.
- `rf_wd`  out  DW  register-file write data.
- `hi_o`  out  DW  current HI, forwarded.
- `lo_o`  out  DW  current LO, forwarded.
- `instret`  out  32  count of retired instructions.

## Operation
- **MEM/WB register capture.** At each rising edge, `valid_q` <= `wb_i_valid & ~wb_i_stall & ~wb_i_flush`.
  - Data fields capture the `wb_i_*` inputs only when the next `valid_q` is 1; otherwise they hold.
  - Flush and stall asserted together produce one bubble; neither has priority.
- **Load extraction** from the registered dmdout:
  - bytesel 1111: the full word.
  - bytesel 0011: bits 15:0, extended per `ldsign`.
  - bytesel 0001: bits 7:0, extended per `ldsign`.
  - Any other code: treated as a word.
- **Register-file write.**
  - `rf_wd` = `dm2rf_q` ? extracted load : `alures_q`.
  - `rf_wa` = `rfwa_q`.
  - `rf_we` = `valid_q & rfwe_q & (rfwa_q != 0)`; a write to $0 is suppressed.
- **HI/LO registers.** At an edge where `valid_q & hilowe_q`, HI <= `mulres_q[2DW-1:DW]` and LO <= `mulres_q[DW-1:0]`.
- **HI/LO forwarding.** `hi_o`/`lo_o` are combinational: `mulres_q` halves when `valid_q & hilowe_q`, else the HI/LO registers.
- **Retire counter.** `instret` increments by 1 at each edge where `valid_q` = 1. It wraps modulo 2^32 (FFFFFFFF -> 0).
- **Independence of writes.** `rf_we` and the HI/LO write are independent; one instruction may assert both.
- **Reset.** While `rst_n` = 0:
  - `valid_q` = 0 and all data fields = 0.
  - HI = LO = `HILO_RST` and `instret` = 0.
  - Hence `rf_we` = 0, `rf_wa` = 0, `rf_wd` = 0, `hi_o` = `lo_o` = `HILO_RST`.
  - Reset asserted mid-operation discards the in-flight WB instruction and any pending HI/LO write.

## Timing
- **Latency.** An instruction presented on `wb_i_*` in cycle N is captured at the edge ending N. `rf_*` is driven during cycle N+1, and the register file commits at the edge ending N+1.
- **HI/LO update.** HI/LO registers update at the edge ending N+1. `hi_o`/`lo_o` reflect the new value from the start of cycle N+1 via forwarding, then from the registers.
- **Retire count.** `instret` reflects the instruction from cycle N+2 onward.
- **Stall.** During a stalled cycle, WB sees a bubble in the next cycle. The held MEM instruction enters WB once, on the cycle `wb_i_stall` deasserts, so it is never retired twice.
- **Throughput.** One instruction per cycle. No combinational path from any `wb_i_*` input to any output.

## Test plan
- **Reset mid-operation.** Assert `rst_n` = 0 while `valid_q` = 1 and `hilowe_q` = 1 -> outputs zero, `hi_o` = `lo_o` = `HILO_RST`, `instret` = 0, HI/LO unchanged by the pending write.
- **Load extraction.** `dmdout` = 0x1234_80F0, `dm2rf` = 1, `rfwa` = 3:
  - bytesel 0001 with ldsign 1 -> `rf_wd` = 0xFFFF_FFF0.
  - bytesel 0001 with ldsign 0 -> 0x0000_00F0.
  - bytesel 0011 with ldsign 1 -> 0xFFFF_80F0.
  - bytesel 1111 -> 0x1234_80F0.
- **$0 write.** `rfwe` = 1, `rfwa` = 0, `alures` = 0xDEAD_BEEF -> `rf_we` = 0; `instret` still increments by 1.
- **HI/LO forwarding.** `mulres` = 0x0000_0001_FFFF_FFFE with `hilowe` in cycle N -> `hi_o` = 1, `lo_o` = 0xFFFF_FFFE in cycle N+1. The values persist after a following bubble.
- **Stall and flush.**
  - `wb_i_stall` = 1 for 3 cycles with `wb_i_valid` = 1, then released -> exactly one `rf_we` pulse and `instret` +1.
  - `wb_i_flush` = 1 with a valid HI/LO write -> no `rf_we`, HI/LO unchanged, `instret` unchanged.
- **Counter wrap.** Preload `instret` to 0xFFFF_FFFF via the backdoor, retire one instruction -> `instret` = 0.
